// File: rtl/iter_muldiv_unit.sv
// Iterative unsigned multiply/divide unit placed between the register file
// read ports and its write port. A shift-add multiplier and a restoring
// divider share one {hi,lo} shift datapath and one iteration counter, so every
// operation takes a fixed WIDTH iterations.
module iter_muldiv_unit #(
  parameter int WIDTH    = 64,
  parameter int REG_ADDR = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [WIDTH-1:0]    operand_a,
  input  logic [WIDTH-1:0]    operand_b,
  input  logic [REG_ADDR-1:0] dest_reg,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    result,
  output logic [REG_ADDR-1:0] result_reg,
  output logic                result_we
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              r_state;
  logic [1:0]          r_op;
  logic [WIDTH-1:0]    r_opnd;
  logic [WIDTH:0]      r_hi;
  logic [WIDTH-1:0]    r_lo;
  logic [REG_ADDR-1:0] r_dest;
  logic [CNT_W-1:0]    r_count;
  logic                r_busy;
  logic                r_done;
  logic                r_we;
  logic [WIDTH-1:0]    r_result;
  logic [REG_ADDR-1:0] r_resultReg;

  logic [WIDTH:0]      w_add;
  logic [WIDTH:0]      w_mulSum;
  logic [WIDTH:0]      w_shift;
  logic [WIDTH:0]      w_diff;
  logic                w_geq;
  logic [WIDTH:0]      w_nextHi;
  logic [WIDTH-1:0]    w_nextLo;
  logic [WIDTH-1:0]    w_final;

  // One iteration step: op[1] picks divide (shift left, trial subtract) or
  // multiply (conditional add, shift right); op[0] picks which half is the answer.
  always_comb begin
    w_add    = r_hi + {1'b0, r_opnd};
    w_mulSum = r_lo[0] ? w_add : r_hi;
    w_shift  = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
    w_geq    = (w_shift >= {1'b0, r_opnd});
    w_diff   = w_shift - {1'b0, r_opnd};
    w_nextHi = r_hi;
    w_nextLo = r_lo;
    if (r_op[1]) begin
      w_nextHi = w_geq ? w_diff : w_shift;
      w_nextLo = {r_lo[WIDTH-2:0], w_geq};
    end else begin
      w_nextHi = {1'b0, w_mulSum[WIDTH:1]};
      w_nextLo = {w_mulSum[0], r_lo[WIDTH-1:1]};
    end
    w_final = r_op[0] ? w_nextHi[WIDTH-1:0] : w_nextLo;
  end

  // Control FSM plus datapath registers; a divisor of zero needs no special
  // case since every trial subtract succeeds, giving all-ones and the dividend.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_opnd      <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_dest      <= '0;
      r_count     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_we        <= 1'b0;
      r_result    <= '0;
      r_resultReg <= '0;
    end else begin
      r_done <= 1'b0;
      r_we   <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_op    <= op;
            r_dest  <= dest_reg;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= op[1] ? operand_a : operand_b;
            r_opnd  <= op[1] ? operand_b : operand_a;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_hi    <= w_nextHi;
          r_lo    <= w_nextLo;
          r_count <= r_count + 1'b1;
          if (r_count == CNT_W'(WIDTH - 1)) begin
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_we        <= (r_dest != '0);
            r_result    <= w_final;
            r_resultReg <= r_dest;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign result     = r_result;
  assign result_reg = r_resultReg;
  assign result_we  = r_we;

endmodule
